// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control unit: FSM state enum,
// base opcodes, ALU-mode and writeback-source encodings, trap cause codes,
// and a helper that maps an opcode to its datapath control bundle.
// No ports (package).
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_MULDIV = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_R   = 2'b01;
   localparam logic [1:0] ALU_I   = 2'b10;

   localparam logic [1:0] WB_PC4  = 2'b00;
   localparam logic [1:0] WB_ALU  = 2'b01;
   localparam logic [1:0] WB_LOAD = 2'b10;
   localparam logic [1:0] WB_NONE = 2'b11;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_IMEM    = 2'b10,
      CAUSE_DMEM    = 2'b11
   } trap_cause_t;

   // Instruction class decides the path after EXEC.
   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_ALU     = 3'd1,
      CLS_BRANCH  = 3'd2,
      CLS_LOAD    = 3'd3,
      CLS_STORE   = 3'd4
   } op_class_t;

   typedef struct packed {
      op_class_t  cls;
      logic       op_a_sel;   // 1: PC, 0: rs1
      logic       op_b_sel;   // 1: imm, 0: rs2
      logic [1:0] alu_op;
      logic [1:0] wb_sel;
      logic       is_jump;    // JAL/JALR redirect the PC to the ALU target
   } op_ctrl_t;

   // Single-cycle decoder encodings, reused unchanged by every state.
   function automatic op_ctrl_t decode_op(input logic [6:0] opc);
      op_ctrl_t c;
      c        = '0;
      c.cls    = CLS_ILLEGAL;
      c.wb_sel = WB_NONE;
      case (opc)
         OPC_LOAD: begin
            c.cls = CLS_LOAD;   c.op_b_sel = 1'b1; c.alu_op = ALU_ADD; c.wb_sel = WB_LOAD;
         end
         OPC_STORE: begin
            c.cls = CLS_STORE;  c.op_b_sel = 1'b1; c.alu_op = ALU_ADD; c.wb_sel = WB_NONE;
         end
         OPC_OP: begin
            c.cls = CLS_ALU;    c.alu_op = ALU_R; c.wb_sel = WB_ALU;
         end
         OPC_OP_IMM: begin
            c.cls = CLS_ALU;    c.op_b_sel = 1'b1; c.alu_op = ALU_I; c.wb_sel = WB_ALU;
         end
         OPC_BRANCH: begin
            c.cls = CLS_BRANCH; c.op_a_sel = 1'b1; c.op_b_sel = 1'b1; c.alu_op = ALU_ADD;
            c.wb_sel = WB_NONE;
         end
         OPC_JAL: begin
            c.cls = CLS_ALU;    c.op_a_sel = 1'b1; c.op_b_sel = 1'b1; c.alu_op = ALU_ADD;
            c.wb_sel = WB_PC4;  c.is_jump = 1'b1;
         end
         OPC_JALR: begin
            c.cls = CLS_ALU;    c.op_b_sel = 1'b1; c.alu_op = ALU_ADD;
            c.wb_sel = WB_PC4;  c.is_jump = 1'b1;
         end
         OPC_LUI: begin
            c.cls = CLS_ALU;    c.op_b_sel = 1'b1; c.alu_op = ALU_ADD; c.wb_sel = WB_ALU;
         end
         OPC_AUIPC: begin
            c.cls = CLS_ALU;    c.op_a_sel = 1'b1; c.op_b_sel = 1'b1; c.alu_op = ALU_ADD;
            c.wb_sel = WB_ALU;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer
// Counts consecutive enabled (not-ready) cycles and flags expiry in the cycle
// in which the TIMEOUT-th consecutive not-ready cycle is seen.
// TIMEOUT = 0 disables the timer (expired_o never asserts).
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   clr_i      clear the count (ready seen or state change)
//   en_i       current cycle is a not-ready wait cycle
//   expired_o  combinational: this wait cycle reaches the limit
// ---------------------------------------------------------------------------
module wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned LIMIT   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam bit          ENABLED = (TIMEOUT > 0);

   logic [CW-1:0] r_count;
   logic          w_at_limit;

   // The count holds the number of earlier wait cycles, so the current wait
   // cycle is the last allowed one when the count equals TIMEOUT-1.
   assign w_at_limit = (r_count == CW'(LIMIT));
   assign expired_o  = ENABLED && en_i && w_at_limit;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_count <= '0;
      end else if (ENABLED && en_i && !w_at_limit) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/MULDIV/WB,
// with ready/valid memory handshakes, wait timeouts into a sticky TRAP state
// and a retired-instruction counter.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   opcode_i, funct7_0_i    instruction fields from the IR
//   branch_taken_i          comparator result (used in EXEC)
//   imem_ready_i            instruction memory ready (used in FETCH)
//   dmem_ready_i            data memory ready (used in MEM)
//   muldiv_done_i           MUL/DIV unit finished (used in MULDIV)
//   imem_req_o, ir_wren_o   fetch request, IR write enable
//   dmem_req_o, mem_wren_o  data request, store write
//   pc_wren_o, br_sel_o     PC update and source (1: ALU target, 0: pc+4)
//   rd_wren_o               register file write enable
//   op_a_sel_o, op_b_sel_o  operand selects, alu_op_o ALU mode
//   wb_sel_o                writeback source (11: none)
//   muldiv_start_o          one-cycle start pulse for MUL/DIV
//   retire_o, instret_o     commit pulse and retired count
//   trap_o, trap_cause_o    sticky trap flag and its cause
// ---------------------------------------------------------------------------
module multicycle_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter bit          HAS_MUL     = 1'b1,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [6:0]       opcode_i,
   input  logic             funct7_0_i,
   input  logic             branch_taken_i,
   input  logic             imem_ready_i,
   input  logic             dmem_ready_i,
   input  logic             muldiv_done_i,
   output logic             imem_req_o,
   output logic             ir_wren_o,
   output logic             dmem_req_o,
   output logic             mem_wren_o,
   output logic             pc_wren_o,
   output logic             br_sel_o,
   output logic             rd_wren_o,
   output logic             op_a_sel_o,
   output logic             op_b_sel_o,
   output logic [1:0]       alu_op_o,
   output logic [1:0]       wb_sel_o,
   output logic             muldiv_start_o,
   output logic             retire_o,
   output logic [CNT_W-1:0] instret_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o
);

   state_t            r_state;
   state_t            w_next_state;
   logic [6:0]        r_opcode;
   logic [CNT_W-1:0]  r_instret;
   trap_cause_t       r_trap_cause;
   trap_cause_t       w_trap_cause;
   logic              r_state_entry;   // first cycle spent in the current state

   op_ctrl_t          w_dec_ctrl;      // decode of the live IR opcode (DECODE)
   op_ctrl_t          w_exe_ctrl;      // decode of the latched opcode (later states)

   logic              w_state_change;
   logic              w_wait_en;
   logic              w_expired;

   logic              w_imem_req, w_ir_wren, w_dmem_req, w_mem_wren;
   logic              w_pc_wren, w_br_sel, w_rd_wren;
   logic              w_op_a_sel, w_op_b_sel, w_muldiv_start, w_retire, w_trap;
   logic [1:0]        w_alu_op, w_wb_sel;

   assign w_dec_ctrl     = decode_op(opcode_i);
   assign w_exe_ctrl     = decode_op(r_opcode);
   assign w_state_change = (w_next_state != r_state);

   // Only FETCH and MEM wait on a ready; readiness elsewhere is ignored.
   assign w_wait_en = ((r_state == S_FETCH) && !imem_ready_i) ||
                      ((r_state == S_MEM)   && !dmem_ready_i);

   // Ready always moves the FSM on, so clearing on a state change also
   // covers clearing on ready.
   wait_timer #(
      .TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (w_state_change),
      .en_i      (w_wait_en),
      .expired_o (w_expired)
   );

   // ---------------- state register ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= S_FETCH;
         r_opcode      <= '0;
         r_instret     <= '0;
         r_trap_cause  <= CAUSE_NONE;
         r_state_entry <= 1'b1;
      end else begin
         r_state       <= w_next_state;
         r_state_entry <= w_state_change;
         if (r_state == S_DECODE) begin
            r_opcode <= opcode_i;
         end
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
         if ((w_next_state == S_TRAP) && (r_state != S_TRAP)) begin
            r_trap_cause <= w_trap_cause;
         end
      end
   end

   // ---------------- next state and control decode ----------------
   // NOTE: every signal written here gets a default before the case so no
   // path leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state   = r_state;
      w_trap_cause   = CAUSE_NONE;
      w_imem_req     = 1'b0;
      w_ir_wren      = 1'b0;
      w_dmem_req     = 1'b0;
      w_mem_wren     = 1'b0;
      w_pc_wren      = 1'b0;
      w_br_sel       = 1'b0;
      w_rd_wren      = 1'b0;
      w_op_a_sel     = 1'b0;
      w_op_b_sel     = 1'b0;
      w_alu_op       = ALU_ADD;
      w_wb_sel       = WB_NONE;
      w_muldiv_start = 1'b0;
      w_retire       = 1'b0;
      w_trap         = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_imem_req = 1'b1;
            if (imem_ready_i) begin
               w_ir_wren    = 1'b1;
               w_next_state = S_DECODE;
            end else if (w_expired) begin
               w_next_state = S_TRAP;
               w_trap_cause = CAUSE_IMEM;
            end
         end

         S_DECODE: begin
            if (w_dec_ctrl.cls == CLS_ILLEGAL) begin
               w_next_state = S_TRAP;
               w_trap_cause = CAUSE_ILLEGAL;
            end else if (HAS_MUL && (opcode_i == OPC_OP) && funct7_0_i) begin
               w_next_state = S_MULDIV;
            end else begin
               w_next_state = S_EXEC;
            end
         end

         S_EXEC: begin
            w_op_a_sel = w_exe_ctrl.op_a_sel;
            w_op_b_sel = w_exe_ctrl.op_b_sel;
            w_alu_op   = w_exe_ctrl.alu_op;
            case (w_exe_ctrl.cls)
               CLS_LOAD, CLS_STORE: w_next_state = S_MEM;
               CLS_BRANCH: begin
                  // Branches commit here; the PC source follows the comparator.
                  w_pc_wren    = 1'b1;
                  w_br_sel     = branch_taken_i;
                  w_retire     = 1'b1;
                  w_next_state = S_FETCH;
               end
               default: w_next_state = S_WB;
            endcase
         end

         S_MEM: begin
            w_dmem_req = 1'b1;
            w_mem_wren = (w_exe_ctrl.cls == CLS_STORE);
            if (dmem_ready_i) begin
               if (w_exe_ctrl.cls == CLS_STORE) begin
                  w_pc_wren    = 1'b1;
                  w_retire     = 1'b1;
                  w_next_state = S_FETCH;
               end else begin
                  w_next_state = S_WB;
               end
            end else if (w_expired) begin
               w_next_state = S_TRAP;
               w_trap_cause = CAUSE_DMEM;
            end
         end

         S_MULDIV: begin
            w_muldiv_start = r_state_entry;
            if (muldiv_done_i) begin
               w_next_state = S_WB;
            end
         end

         S_WB: begin
            w_rd_wren    = 1'b1;
            w_pc_wren    = 1'b1;
            w_br_sel     = w_exe_ctrl.is_jump;
            w_wb_sel     = w_exe_ctrl.wb_sel;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end

         S_TRAP: begin
            w_trap = 1'b1;
         end

         default: w_next_state = S_FETCH;
      endcase
   end

   // Reset forces every strobe idle in the reset cycle itself, so an aborted
   // instruction can never write anything.
   assign imem_req_o     = w_imem_req     & ~rst_i;
   assign ir_wren_o      = w_ir_wren      & ~rst_i;
   assign dmem_req_o     = w_dmem_req     & ~rst_i;
   assign mem_wren_o     = w_mem_wren     & ~rst_i;
   assign pc_wren_o      = w_pc_wren      & ~rst_i;
   assign br_sel_o       = w_br_sel       & ~rst_i;
   assign rd_wren_o      = w_rd_wren      & ~rst_i;
   assign op_a_sel_o     = w_op_a_sel     & ~rst_i;
   assign op_b_sel_o     = w_op_b_sel     & ~rst_i;
   assign muldiv_start_o = w_muldiv_start & ~rst_i;
   assign retire_o       = w_retire       & ~rst_i;
   assign trap_o         = w_trap         & ~rst_i;
   assign alu_op_o       = rst_i ? ALU_ADD : w_alu_op;
   assign wb_sel_o       = rst_i ? WB_NONE : w_wb_sel;
   assign instret_o      = r_instret;
   assign trap_cause_o   = r_trap_cause;

endmodule
